// File: rtl/pattern_det_pkg.sv
// Shared helpers for the Moore pattern detector: state sizing and the
// elaboration-time KMP transition function.
package pattern_det_pkg;

    localparam int unsigned MAX_PAT_W = 1024;
    localparam int unsigned MAX_SYM_W = 32;

    function automatic int unsigned state_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // The MATCH state is the index equal to the pattern length.
    function automatic int unsigned match_index(input int unsigned len);
        return len;
    endfunction

    // Symbol idx of the pattern, idx 0 being the first symbol expected.
    function automatic logic [MAX_SYM_W-1:0] pattern_sym(
        input logic [MAX_PAT_W-1:0] pattern,
        input int unsigned          len,
        input int unsigned          sym_w,
        input int unsigned          idx
    );
        logic [MAX_SYM_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < sym_w; b++) begin
            r[b] = pattern[(len - 1 - idx) * sym_w + b];
        end
        return r;
    endfunction

    // Longest j <= len with prefix(j) a suffix of prefix(k) followed by s.
    function automatic int unsigned build_next_state(
        input logic [MAX_PAT_W-1:0] pattern,
        input int unsigned          len,
        input int unsigned          sym_w,
        input int unsigned          k,
        input logic [MAX_SYM_W-1:0] s
    );
        int unsigned          best;
        int unsigned          p;
        logic                 ok;
        logic [MAX_SYM_W-1:0] c;
        best = 0;
        for (int unsigned j = 1; j <= len; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < j; i++) begin
                    p = k + 1 - j + i;
                    c = (p < k) ? pattern_sym(pattern, len, sym_w, p) : s;
                    if (c != pattern_sym(pattern, len, sym_w, i)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/pattern_detector_moore.sv
// Parametrised Moore sequence detector with overlap control and a
// saturating match counter; outputs depend on registered state only.
module pattern_detector_moore
    import pattern_det_pkg::*;
#(
    parameter int unsigned             SYM_W   = 1,
    parameter int unsigned             LEN     = 2,
    parameter logic [LEN*SYM_W-1:0]    PATTERN = 'b01,
    parameter bit                      OVERLAP = 1'b1,
    parameter int unsigned             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             clear,
    output logic             y,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned SW    = state_width(LEN);
    localparam int unsigned NST   = 2 ** SW;
    localparam int unsigned NSYM  = 2 ** SYM_W;
    localparam logic [SW-1:0]    MATCH    = SW'(match_index(LEN));
    localparam logic [CNT_W-1:0] CNT_LAST = ~CNT_W'(1);

    if (LEN < 2 || LEN > 16 || CNT_W < 1 || SYM_W < 1 ||
        SYM_W > MAX_SYM_W || LEN * SYM_W > MAX_PAT_W) begin : g_param_check
        $error("pattern_detector_moore: illegal parameter set");
    end

    // Rows beyond LEN are unreachable and padded so state can index directly.
    logic [SW-1:0] tbl [NST][NSYM];

    for (genvar k = 0; k < NST; k++) begin : g_row
        for (genvar s = 0; s < NSYM; s++) begin : g_col
            if (k <= LEN) begin : g_live
                localparam logic [SW-1:0] NX = SW'(build_next_state(
                    MAX_PAT_W'(PATTERN), LEN, SYM_W, k, MAX_SYM_W'(s)));
                assign tbl[k][s] = NX;
            end else begin : g_pad
                assign tbl[k][s] = '0;
            end
        end
    end

    logic [SW-1:0] state;
    logic [SW-1:0] state_nx;
    logic          hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= '0;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        hit      = 1'b0;
        if (clear) begin
            state_nx = '0;
        end else if (valid_in) begin
            if (!OVERLAP && state == MATCH) state_nx = tbl[0][sym_in];
            else                            state_nx = tbl[state][sym_in];
            hit = (state_nx == MATCH);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_pulse <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (clear) begin
            match_pulse <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            match_pulse <= hit;
            if (hit && match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
                if (match_count == CNT_LAST) count_sat <= 1'b1;
            end
        end
    end

    always_comb begin
        y = (state == MATCH);
    end

endmodule

// File: tb/tb_pattern_detector_moore.sv
// Drives five detector configurations from one shared stream and checks them
// against a sliding-window reference model of accepted symbols.
module tb_pattern_detector_moore;

    logic       clk;
    logic       reset_n;
    logic       valid_in;
    logic [1:0] sym_in;
    logic       clear;

    logic [4:0] y_o;
    logic [4:0] mp_o;
    logic [4:0] sat_o;
    logic [7:0] cnt_o [5];
    logic [1:0] cnt4;

    int checks = 0;
    int errors = 0;

    int    pat  [5][3];
    int    plen [5];
    bit    ovl  [5];
    int    cmax [5];
    int    smask[5];
    int    hist [5][$];
    bit    m_y  [5];
    bit    m_p  [5];
    bit    m_s  [5];
    int    m_c  [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pattern_detector_moore d0 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .sym_in(sym_in[0]),
        .clear(clear), .y(y_o[0]), .match_pulse(mp_o[0]),
        .match_count(cnt_o[0]), .count_sat(sat_o[0]));

    pattern_detector_moore #(.SYM_W(2), .LEN(3), .PATTERN(6'b01_01_10), .OVERLAP(1'b1)) d1 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .sym_in(sym_in),
        .clear(clear), .y(y_o[1]), .match_pulse(mp_o[1]),
        .match_count(cnt_o[1]), .count_sat(sat_o[1]));

    pattern_detector_moore #(.SYM_W(1), .LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1)) d2 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .sym_in(sym_in[0]),
        .clear(clear), .y(y_o[2]), .match_pulse(mp_o[2]),
        .match_count(cnt_o[2]), .count_sat(sat_o[2]));

    pattern_detector_moore #(.SYM_W(1), .LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0)) d3 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .sym_in(sym_in[0]),
        .clear(clear), .y(y_o[3]), .match_pulse(mp_o[3]),
        .match_count(cnt_o[3]), .count_sat(sat_o[3]));

    pattern_detector_moore #(.CNT_W(2)) d4 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .sym_in(sym_in[0]),
        .clear(clear), .y(y_o[4]), .match_pulse(mp_o[4]),
        .match_count(cnt4), .count_sat(sat_o[4]));

    assign cnt_o[4] = {6'b0, cnt4};

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            hist[i].delete();
            m_y[i] = 1'b0;
            m_p[i] = 1'b0;
            m_s[i] = 1'b0;
            m_c[i] = 0;
        end
    endtask

    // A match is declared when the last LEN accepted symbols equal the pattern.
    task automatic model_step(input bit v, input int s, input bit c);
        bit hit;
        for (int i = 0; i < 5; i++) begin
            if (c) begin
                hist[i].delete();
                m_y[i] = 1'b0; m_p[i] = 1'b0; m_s[i] = 1'b0; m_c[i] = 0;
            end else if (v) begin
                hist[i].push_back(s & smask[i]);
                while (hist[i].size() > plen[i]) void'(hist[i].pop_front());
                hit = (hist[i].size() == plen[i]);
                for (int j = 0; j < plen[i]; j++)
                    if (hit && hist[i][j] != pat[i][j]) hit = 1'b0;
                m_y[i] = hit;
                m_p[i] = hit;
                if (hit) begin
                    if (m_c[i] < cmax[i]) m_c[i] = m_c[i] + 1;
                    if (m_c[i] == cmax[i]) m_s[i] = 1'b1;
                    if (!ovl[i]) hist[i].delete();
                end
            end else begin
                m_p[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 5; i++) begin
            checks++;
            assert (y_o[i] === m_y[i]) else begin
                errors++;
                $error("FAIL %s y[%0d] got %b exp %b", tag, i, y_o[i], m_y[i]);
            end
            checks++;
            assert (mp_o[i] === m_p[i]) else begin
                errors++;
                $error("FAIL %s match_pulse[%0d] got %b exp %b", tag, i, mp_o[i], m_p[i]);
            end
            checks++;
            assert (cnt_o[i] === 8'(m_c[i])) else begin
                errors++;
                $error("FAIL %s match_count[%0d] got %0d exp %0d", tag, i, cnt_o[i], m_c[i]);
            end
            checks++;
            assert (sat_o[i] === m_s[i]) else begin
                errors++;
                $error("FAIL %s count_sat[%0d] got %b exp %b", tag, i, sat_o[i], m_s[i]);
            end
        end
    endtask

    task automatic step(input string tag, input bit v, input logic [1:0] s, input bit c);
        valid_in = v;
        sym_in   = s;
        clear    = c;
        @(posedge clk);
        model_step(v, int'(s), c);
        #1;
        check_all(tag);
    endtask

    task automatic feed(input string tag, input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, {1'b0, bits[i]}, 1'b0);
    endtask

    initial begin
        pat[0] = '{0, 1, 0}; plen[0] = 2; ovl[0] = 1; cmax[0] = 255; smask[0] = 1;
        pat[1] = '{1, 1, 2}; plen[1] = 3; ovl[1] = 1; cmax[1] = 255; smask[1] = 3;
        pat[2] = '{1, 0, 1}; plen[2] = 3; ovl[2] = 1; cmax[2] = 255; smask[2] = 1;
        pat[3] = '{1, 0, 1}; plen[3] = 3; ovl[3] = 0; cmax[3] = 255; smask[3] = 1;
        pat[4] = '{0, 1, 0}; plen[4] = 2; ovl[4] = 1; cmax[4] = 3;   smask[4] = 1;

        reset_n  = 1'b0;
        valid_in = 1'b0;
        sym_in   = 2'b00;
        clear    = 1'b0;
        model_reset();
        #1 check_all("reset");
        #12 reset_n = 1'b1;

        feed("stream110101", 6, 16'b110101);

        step("clear1", 1'b1, 2'd1, 1'b1);
        step("sym2_a", 1'b1, 2'd1, 1'b0);
        step("sym2_b", 1'b1, 2'd1, 1'b0);
        step("sym2_c", 1'b1, 2'd1, 1'b0);
        step("sym2_d", 1'b1, 2'd2, 1'b0);

        step("clear2", 1'b0, 2'd0, 1'b1);
        feed("ovl10101", 5, 16'b10101);
        feed("nonovl_tail", 1, 16'b1);

        step("clear3", 1'b0, 2'd0, 1'b1);
        feed("hold_pre", 2, 16'b01);
        for (int i = 0; i < 5; i++) step("hold_idle", 1'b0, 2'bxx, 1'b0);

        step("clear4", 1'b0, 2'd0, 1'b1);
        feed("sat", 10, 16'b0101010101);
        step("clear_sat", 1'b1, 2'd1, 1'b1);
        step("post_clear", 1'b0, 2'd0, 1'b0);

        feed("pre_reset", 1, 16'b0);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all("async_reset");
        #20 reset_n = 1'b1;
        feed("post_reset", 2, 16'b01);

        for (int n = 0; n < 400; n++) begin
            step("random", ($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
